// File: rtl/way_replacement_controller.sv
// way_replacement_controller: per-set controller for lookup, write-back and fill across NUM_WAYS ways.
// It keeps true-LRU ages, where age 0 is the most recently used way and NUM_WAYS-1 is the LRU way.
// It also drives one-hot way strobes and picks the miss victim.
// Optional macro WAY_STATS_EN adds three saturating 32-bit event counters:
// hitCount, missCount and wbCount.
module way_replacement_controller #(
    parameter int NUM_WAYS      = 4,
    parameter int COUNTER_WIDTH = 8,
    parameter int ADDRESS_WIDTH = 32,
    parameter int BLOCK_SIZE    = 32,
    localparam int OFFSET_WIDTH = $clog2(BLOCK_SIZE),
    localparam int TAG_WIDTH    = ADDRESS_WIDTH - OFFSET_WIDTH,
    localparam int IDX_W        = $clog2(NUM_WAYS)
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              reqValid,
    output logic                              reqReady,
    input  logic [ADDRESS_WIDTH-1:0]          reqAddr,
    input  logic                              reqWrite,
    input  logic [NUM_WAYS-1:0]               hitVector,
    input  logic [NUM_WAYS-1:0]               wayValid,
    input  logic [NUM_WAYS-1:0]               wayDirty,
    output logic [TAG_WIDTH-1:0]              lookupTag,
    output logic [NUM_WAYS-1:0]               accessed,
    output logic                              updateAge,
    output logic [NUM_WAYS*COUNTER_WIDTH-1:0] wayAge,
    output logic [NUM_WAYS-1:0]               wEn,
    output logic [NUM_WAYS-1:0]               allocate,
    output logic                              wbReq,
    output logic [NUM_WAYS-1:0]               wbWay,
    input  logic                              wbAck,
    output logic                              fillReq,
    input  logic                              fillAck,
    output logic                              respValid,
    output logic                              respHit,
`ifdef WAY_STATS_EN
    output logic [31:0]                       hitCount,
    output logic [31:0]                       missCount,
    output logic [31:0]                       wbCount,
`endif
    output logic [NUM_WAYS-1:0]               respWay
);

    typedef enum logic [2:0] {IDLE, LOOKUP, WRITEBACK, FILL, RESP} state_t;

    state_t                                  state;
    logic                                    reqWriteQ;
    logic [IDX_W-1:0]                        victimQ;
    logic [NUM_WAYS-1:0][COUNTER_WIDTH-1:0]  ageQ;
    logic [NUM_WAYS-1:0][COUNTER_WIDTH-1:0]  ageNext;
    logic [IDX_W-1:0]                        hitIdx;
    logic [IDX_W-1:0]                        victimIdx;
    logic [IDX_W-1:0]                        touchIdx;
    logic                                    anyHit;
    logic                                    touchEn;
    logic                                    unusedOffset;

    // The offset bits never reach the ways; the tag is the only address information broadcast.
    assign unusedOffset = ^reqAddr[OFFSET_WIDTH-1:0];
    assign wayAge       = ageQ;
    assign anyHit       = |hitVector;

    // Priority picks: lowest hitting way, and a victim that is the lowest invalid way or else the LRU way.
    always_comb begin
        hitIdx    = '0;
        victimIdx = '0;
        for (int i = NUM_WAYS - 1; i >= 0; i--) begin
            if (hitVector[i]) hitIdx = IDX_W'(i);
        end
        for (int i = 0; i < NUM_WAYS; i++) begin
            if (ageQ[i] == COUNTER_WIDTH'(NUM_WAYS - 1)) victimIdx = IDX_W'(i);
        end
        for (int i = NUM_WAYS - 1; i >= 0; i--) begin
            if (!wayValid[i]) victimIdx = IDX_W'(i);
        end
    end

    // A touch happens on a lookup hit, or when fill data arrives for the victim.
    assign touchEn  = ((state == LOOKUP) && anyHit) || ((state == FILL) && fillAck);
    assign touchIdx = (state == LOOKUP) ? hitIdx : victimQ;

    // Per-way age after touching touchIdx: the touched way becomes 0, and younger ways age by one.
    for (genvar g = 0; g < NUM_WAYS; g++) begin : gAge
        assign ageNext[g] = (touchIdx == IDX_W'(g))     ? '0 :
                            (ageQ[g] < ageQ[touchIdx])  ? ageQ[g] + COUNTER_WIDTH'(1) :
                                                          ageQ[g];
    end

    // Main FSM with registered strobes, handshakes and LRU ages.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            reqReady  <= 1'b1;
            reqWriteQ <= 1'b0;
            victimQ   <= '0;
            lookupTag <= '0;
            accessed  <= '0;
            updateAge <= 1'b0;
            wEn       <= '0;
            allocate  <= '0;
            wbReq     <= 1'b0;
            wbWay     <= '0;
            fillReq   <= 1'b0;
            respValid <= 1'b0;
            respHit   <= 1'b0;
            respWay   <= '0;
            for (int i = 0; i < NUM_WAYS; i++) ageQ[i] <= COUNTER_WIDTH'(i);
`ifdef WAY_STATS_EN
            hitCount  <= '0;
            missCount <= '0;
            wbCount   <= '0;
`endif
        end else begin
            accessed  <= '0;
            updateAge <= 1'b0;
            wEn       <= '0;
            allocate  <= '0;
            respValid <= 1'b0;
            if (touchEn) ageQ <= ageNext;
            case (state)
                IDLE: if (reqValid) begin
                    lookupTag <= reqAddr[ADDRESS_WIDTH-1:OFFSET_WIDTH];
                    reqWriteQ <= reqWrite;
                    reqReady  <= 1'b0;
                    state     <= LOOKUP;
                end
                LOOKUP: begin
                    if (anyHit) begin
                        accessed  <= NUM_WAYS'(1) << hitIdx;
                        updateAge <= 1'b1;
                        wEn       <= reqWriteQ ? NUM_WAYS'(1) << hitIdx : '0;
                        respHit   <= 1'b1;
                        respWay   <= NUM_WAYS'(1) << hitIdx;
                        respValid <= 1'b1;
                        state     <= RESP;
`ifdef WAY_STATS_EN
                        if (hitCount != '1) hitCount <= hitCount + 32'd1;
`endif
                    end else begin
                        victimQ <= victimIdx;
                        respHit <= 1'b0;
                        if (wayValid[victimIdx] && wayDirty[victimIdx]) begin
                            wbReq <= 1'b1;
                            wbWay <= NUM_WAYS'(1) << victimIdx;
                            state <= WRITEBACK;
                        end else begin
                            fillReq <= 1'b1;
                            state   <= FILL;
                        end
`ifdef WAY_STATS_EN
                        if (missCount != '1) missCount <= missCount + 32'd1;
`endif
                    end
                end
                WRITEBACK: if (wbAck) begin
                    wbReq   <= 1'b0;
                    wbWay   <= '0;
                    fillReq <= 1'b1;
                    state   <= FILL;
`ifdef WAY_STATS_EN
                    if (wbCount != '1) wbCount <= wbCount + 32'd1;
`endif
                end
                FILL: if (fillAck) begin
                    fillReq   <= 1'b0;
                    allocate  <= NUM_WAYS'(1) << victimQ;
                    accessed  <= NUM_WAYS'(1) << victimQ;
                    updateAge <= 1'b1;
                    wEn       <= reqWriteQ ? NUM_WAYS'(1) << victimQ : '0;
                    respWay   <= NUM_WAYS'(1) << victimQ;
                    respValid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    respHit  <= 1'b0;
                    respWay  <= '0;
                    reqReady <= 1'b1;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_way_replacement_controller.sv
// Directed self-checking bench for way_replacement_controller with the default 4-way, 8-bit age configuration.
module tb_way_replacement_controller;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        reqValid = 1'b0;
    logic        reqReady;
    logic [31:0] reqAddr = '0;
    logic        reqWrite = 1'b0;
    logic [3:0]  hitVector = '0;
    logic [3:0]  wayValid = '0;
    logic [3:0]  wayDirty = '0;
    logic [26:0] lookupTag;
    logic [3:0]  accessed;
    logic        updateAge;
    logic [31:0] wayAge;
    logic [3:0]  wEn;
    logic [3:0]  allocate;
    logic        wbReq;
    logic [3:0]  wbWay;
    logic        wbAck = 1'b0;
    logic        fillReq;
    logic        fillAck = 1'b0;
    logic        respValid;
    logic        respHit;
    logic [3:0]  respWay;

    int total = 0;
    int bad   = 0;

    way_replacement_controller dut (
        .clk(clk), .rst_n(rst_n), .reqValid(reqValid), .reqReady(reqReady),
        .reqAddr(reqAddr), .reqWrite(reqWrite), .hitVector(hitVector),
        .wayValid(wayValid), .wayDirty(wayDirty), .lookupTag(lookupTag),
        .accessed(accessed), .updateAge(updateAge), .wayAge(wayAge), .wEn(wEn),
        .allocate(allocate), .wbReq(wbReq), .wbWay(wbWay), .wbAck(wbAck),
        .fillReq(fillReq), .fillAck(fillAck), .respValid(respValid),
        .respHit(respHit), .respWay(respWay)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents a request for one accepting edge, then drops reqValid.
    task automatic request(input logic [31:0] addr, input logic wr, input logic [3:0] hv);
        reqValid  = 1'b1;
        reqAddr   = addr;
        reqWrite  = wr;
        hitVector = hv;
        tick();
        reqValid  = 1'b0;
    endtask

    // Hit on way one-hot w: checks the response pulse, then returns to IDLE.
    task automatic hitOn(input string tag, input logic [3:0] w);
        request(32'h0000_1000, 1'b0, w);
        tick();
        chk({tag, ".respValid"}, respValid, 1'b1);
        chk({tag, ".respWay"}, respWay, w);
        tick();
    endtask

    initial begin
        wayValid = 4'b1111;
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Reset state
        chk("rst.reqReady", reqReady, 1'b1);
        chk("rst.wayAge", wayAge, 32'h0302_0100);
        chk("rst.strobes", {accessed, updateAge, wEn, allocate}, 13'h0);
        chk("rst.hs", {wbReq, fillReq, respValid}, 3'b000);

        // Read hit on way2
        request(32'h1234_5678, 1'b0, 4'b0100);
        chk("hit.reqReady", reqReady, 1'b0);
        chk("hit.lookupTag", lookupTag, 27'(32'h1234_5678 >> 5));
        chk("hit.respValidEarly", respValid, 1'b0);
        tick();
        chk("hit.respValid", respValid, 1'b1);
        chk("hit.respHit", respHit, 1'b1);
        chk("hit.respWay", respWay, 4'b0100);
        chk("hit.accessed", accessed, 4'b0100);
        chk("hit.updateAge", updateAge, 1'b1);
        chk("hit.wEn", wEn, 4'b0000);
        tick();
        chk("hit.idle", {reqReady, respValid, accessed, updateAge}, {1'b1, 1'b0, 4'b0000, 1'b0});
        chk("hit.wayAge", wayAge, 32'h0300_0201);

        // Write miss with invalid way2, which is a clean fill
        wayValid = 4'b1011;
        request(32'h0000_0040, 1'b1, 4'b0000);
        tick();
        chk("miss.fillReq", fillReq, 1'b1);
        chk("miss.wbReq", wbReq, 1'b0);
        tick();
        tick();
        chk("miss.fillHeld", {fillReq, respValid}, 2'b10);
        fillAck = 1'b1;
        tick();
        fillAck = 1'b0;
        chk("miss.allocate", allocate, 4'b0100);
        chk("miss.wEn", wEn, 4'b0100);
        chk("miss.accessed", accessed, 4'b0100);
        chk("miss.fillReqDrop", fillReq, 1'b0);
        chk("miss.resp", {respValid, respHit, respWay}, {1'b1, 1'b0, 4'b0100});
        tick();
        chk("miss.wayAge", wayAge, 32'h0300_0201);
        chk("miss.strobeClear", {allocate, wEn, respValid}, 9'h0);

        // Dirty miss with all ways valid: LRU way3 is written back first
        wayValid = 4'b1111;
        wayDirty = 4'b1000;
        request(32'h0000_0080, 1'b0, 4'b0000);
        tick();
        chk("wb.wbReq", wbReq, 1'b1);
        chk("wb.wbWay", wbWay, 4'b1000);
        chk("wb.noFill", fillReq, 1'b0);
        for (int i = 0; i < 4; i++) begin
            fillAck = (i == 1);
            tick();
            chk("wb.held", {wbReq, wbWay, fillReq}, {1'b1, 4'b1000, 1'b0});
        end
        fillAck = 1'b0;
        wbAck = 1'b1;
        tick();
        wbAck = 1'b0;
        chk("wb.toFill", {wbReq, wbWay, fillReq}, {1'b0, 4'b0000, 1'b1});
        tick();
        fillAck = 1'b1;
        tick();
        fillAck = 1'b0;
        chk("wb.allocate", allocate, 4'b1000);
        chk("wb.wEn", wEn, 4'b0000);
        chk("wb.resp", {respValid, respHit, respWay}, {1'b1, 1'b0, 4'b1000});
        tick();
        chk("wb.wayAge", wayAge, 32'h0001_0302);
        wayDirty = 4'b0000;

        // Four hits in way order leave way0 as the LRU way
        hitOn("h0", 4'b0001);
        hitOn("h1", 4'b0010);
        hitOn("h2", 4'b0100);
        hitOn("h3", 4'b1000);
        chk("seq.wayAge", wayAge, 32'h0001_0203);
        request(32'h0000_00c0, 1'b0, 4'b0000);
        tick();
        chk("lru.fillReq", {fillReq, wbReq}, 2'b10);
        fillAck = 1'b1;
        tick();
        fillAck = 1'b0;
        chk("lru.allocate", allocate, 4'b0001);
        tick();
        chk("lru.wayAge", wayAge, 32'h0102_0300);

        // Reset during FILL abandons the transaction
        request(32'h0000_0100, 1'b0, 4'b0000);
        tick();
        chk("rstf.inFill", fillReq, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("rstf.clear", {fillReq, reqReady, respValid, allocate}, {1'b0, 1'b1, 1'b0, 4'b0000});
        chk("rstf.wayAge", wayAge, 32'h0302_0100);
        tick();
        rst_n = 1'b1;
        fillAck = 1'b1;
        wbAck = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rstf.ignore", {respValid, allocate, fillReq, wbReq, reqReady}, {1'b0, 4'b0000, 1'b0, 1'b0, 1'b1});
        end
        fillAck = 1'b0;
        wbAck = 1'b0;

        // A multi-hot write hit selects the lowest hitting way
        request(32'h0000_0200, 1'b1, 4'b0110);
        tick();
        chk("mh.respWay", respWay, 4'b0010);
        chk("mh.wEn", wEn, 4'b0010);
        tick();
        chk("mh.wayAge", wayAge, 32'h0302_0001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/way_replacement_controller.md
Name: way_replacement_controller

Overview:
- Per-set controller that sequences lookup, eviction and allocation across NUM_WAYS cache ways.
- Keeps true-LRU age counters, drives each way's accessed/updateAge/allocate/wEn strobes, and picks the victim.
- Handshakes write-back and fill with the memory side.
- Sits between the core request port and the way array of one set.

Parameters:
NUM_WAYS, 4, ways per set (power of two, >=2)
COUNTER_WIDTH, 8, age counter width; must be >= $clog2(NUM_WAYS)
ADDRESS_WIDTH, 32, request address width
BLOCK_SIZE, 32, bytes per block; OFFSET_WIDTH = $clog2(BLOCK_SIZE)

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
reqValid  input  1  core request valid
reqReady  output  1  controller can accept request
reqAddr  input  ADDRESS_WIDTH  request address
reqWrite  input  1  1 = write, 0 = read
hitVector  input  NUM_WAYS  per-way tag match AND valid, from ways
wayValid  input  NUM_WAYS  per-way valid bits
wayDirty  input  NUM_WAYS  per-way dirty bits
lookupTag  output  ADDRESS_WIDTH-OFFSET_WIDTH  registered tag broadcast to ways
accessed  output  NUM_WAYS  one-hot accessed-way strobe
updateAge  output  1  pulse: ways latch new age
wayAge  output  NUM_WAYS*COUNTER_WIDTH  packed age of each way
wEn  output  NUM_WAYS  one-hot way write enable
allocate  output  NUM_WAYS  one-hot allocate strobe
wbReq  output  1  write-back request (victim dirty)
wbWay  output  NUM_WAYS  one-hot victim being written back
wbAck  input  1  memory accepted write-back
fillReq  output  1  fill request for lookupTag
fillAck  input  1  fill data available
respValid  output  1  one-cycle response pulse
respHit  output  1  response was a hit
respWay  output  NUM_WAYS  one-hot way serviced

Behaviour:
- Reset: clk domain, async assert, sync deassert by the system. All outputs 0 except reqReady=1. State IDLE. age[i]=i (way 0 MRU). Reset mid-transaction abandons it; no respValid.
- FSM states: IDLE, LOOKUP, WRITEBACK, FILL, RESP.
- IDLE: reqReady=1. On reqValid, register reqAddr[ADDRESS_WIDTH-1:OFFSET_WIDTH] into lookupTag and register reqWrite; go to LOOKUP. reqReady=0 in all other states.
- LOOKUP (exactly 1 cycle): sample hitVector.
  - Hit: way = lowest set bit if multi-hot. Touch(way). wEn[way]=reqWrite. Go to RESP with respHit=1.
  - Miss: victim = lowest-index way with wayValid=0. If none, the way with age==NUM_WAYS-1. Register the victim.
  - Miss with victim valid and dirty: go to WRITEBACK. Otherwise: go to FILL.
- WRITEBACK: wbReq=1 and wbWay=victim, held until the cycle wbAck=1; then go to FILL. wbAck outside WRITEBACK is ignored.
- FILL: fillReq=1 until fillAck=1. In the fillAck cycle: allocate[victim]=1, Touch(victim), wEn[victim]=reqWrite. Go to RESP with respHit=0. fillAck outside FILL is ignored.
- RESP: respValid=1 for 1 cycle, respWay=serviced way, respHit held; go to IDLE.
- Touch(w): single-cycle pulse with accessed=onehot(w) and updateAge=1.
  - Next cycle: age[w]=0.
  - Every j with age[j]<old age[w] increments by 1.
  - All others unchanged.
  - Ages always remain a permutation of 0..NUM_WAYS-1, so no overflow and no saturation is needed.
- Strobes accessed, updateAge, wEn and allocate are single-cycle; 0 otherwise.
- Latency: hit = request accepted at T, respValid at T+2. Clean miss = respValid 1 cycle after fillAck. Dirty miss adds the WRITEBACK wait.
- Back-to-back: a new request can be accepted in the cycle after RESP (IDLE).

Optional Feature:
WAY_STATS_EN
- Defined: adds outputs hitCount, missCount and wbCount, each 32 bits, reset 0, saturating at all-ones.
  - hitCount/missCount increment at the LOOKUP decision.
  - wbCount increments on wbAck in WRITEBACK.
- Undefined: these ports and counters do not exist. Behaviour is otherwise identical.

Test Plan:
- Reset → reqReady=1, wayAge={3,2,1,0} (way3..way0), all strobes 0.
- Read hit, hitVector=0100 → respValid at T+2, respHit=1, respWay=0100, accessed=0100. Ages way2=0, way0=1, way1=2, way3 unchanged=3.
- Miss, wayValid=1011 → victim way2, no wbReq. fillReq until fillAck, then allocate=0100 and wEn=0100 (write request). respHit=0.
- Miss, all valid, LRU way3 dirty → wbReq=1, wbWay=1000, held 5 cycles until wbAck. Then FILL, then allocate=1000.
- 4 hits in order way0,1,2,3 → final ages way3=0, way2=1, way1=2, way0=3. Next all-valid clean miss evicts way0.
- rst_n asserted low during FILL → outputs clear immediately, state IDLE, no respValid. A fillAck arriving after reset is ignored.
